// File: rtl/gear_box_pkg.sv
// Shared constants and helpers for the parametrised gear box.
// Holds the default word/accumulator widths, the flush FSM encodings
// and a constant clog2 used to size the fill counter.
package gear_box_pkg;

   localparam int GB_IN_W  = 13;
   localparam int GB_OUT_W = 8;
   localparam int GB_BUF_W = 32;

   // IDLE: normal packing; DRAIN: residue is being pushed out, input blocked.
   typedef enum logic {
      GB_IDLE  = 1'b0,
      GB_DRAIN = 1'b1
   } gb_flush_state_e;

   // Smallest n with 2**n >= value.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/gear_box_bit_buffer.sv
// Bit accumulator for the gear box: holds buf/fill and merges/shifts words.
// Ports: in_data + push append a word at the fill point, pop drops OUT_W
// LSBs, drain_last forces fill to 0 on the final zero-padded pop.
module gear_box_bit_buffer
   import gear_box_pkg::*;
#(
   parameter int IN_W   = GB_IN_W,
   parameter int OUT_W  = GB_OUT_W,
   parameter int BUF_W  = GB_BUF_W,
   parameter int FILL_W = clog2(BUF_W + 1)
) (
   input  logic              clk,
   input  logic              sys_reset,
   input  logic [IN_W-1:0]   in_data,
   input  logic              push,
   input  logic              pop,
   input  logic              drain_last,
   output logic [BUF_W-1:0]  buf_bits,
   output logic [FILL_W-1:0] fill
);

   // Merge is done one input word wider than the buffer so the shifted
   // word never loses bits before truncation.
   localparam int EXT_W = BUF_W + IN_W;
   localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);
   localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

   logic [BUF_W-1:0]  buf_q, buf_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [EXT_W-1:0]  base_ext;
   logic [EXT_W-1:0]  word_ext;
   logic [EXT_W-1:0]  merged_ext;
   logic [FILL_W-1:0] ins_pos;
   logic              unused_ext;

   always_comb begin
      base_ext   = {{IN_W{1'b0}}, buf_q};
      word_ext   = {{BUF_W{1'b0}}, in_data};
      ins_pos    = fill_q;
      fill_d     = fill_q;
      if (pop) begin
         base_ext = base_ext >> OUT_W;
         // Only used when a push coincides, which implies fill >= OUT_W.
         ins_pos  = fill_q - OUT_W_F;
         fill_d   = drain_last ? '0 : (fill_q - OUT_W_F);
      end
      merged_ext = base_ext;
      if (push) begin
         merged_ext = base_ext | (word_ext << ins_pos);
         fill_d     = fill_d + IN_W_F;
      end
      // in_ready guarantees fill + IN_W <= BUF_W, so the top bits are zero.
      buf_d = merged_ext[BUF_W-1:0];
   end

   assign unused_ext = ^merged_ext;

   always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         buf_q  <= '0;
         fill_q <= '0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
      end
   end

   assign buf_bits = buf_q;
   assign fill     = fill_q;

endmodule

// File: rtl/param_gear_box.sv
// Parametrised IN_W -> OUT_W width converter (LSB-first) with valid/ready.
// Ports: in_* / out_* handshakes, flush pulse, fill_level = held bit count.
// Macro PARAM_GEAR_BOX_FLUSH_EN enables the flush/drain of the residue.
module param_gear_box
   import gear_box_pkg::*;
#(
   parameter int IN_W   = GB_IN_W,
   parameter int OUT_W  = GB_OUT_W,
   parameter int BUF_W  = GB_BUF_W,
   parameter int FILL_W = clog2(BUF_W + 1)
) (
   input  logic              clk,
   input  logic              sys_reset,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              flush,
   output logic [FILL_W-1:0] fill_level
);

   localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
   localparam logic [FILL_W-1:0] ROOM_F  = FILL_W'(BUF_W - IN_W);

   logic              push;
   logic              pop;
   logic              flush_pend;
   logic              drain_last;
   logic [BUF_W-1:0]  buf_bits;
   logic [FILL_W-1:0] fill;
   logic              unused_buf;

   // Handshakes depend on registered state only; out_ready never reaches in_ready.
   assign in_ready   = (fill <= ROOM_F) & ~flush_pend;
   assign out_valid  = (fill >= OUT_W_F) | (flush_pend & (fill != '0));
   assign out_data   = buf_bits[OUT_W-1:0];
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign fill_level = fill;
   assign unused_buf = ^buf_bits;

`ifdef PARAM_GEAR_BOX_FLUSH_EN
   gb_flush_state_e state_q, state_d;
   logic            fill_next_zero;

   // Fill after this edge is zero: nothing arrives and either nothing is
   // held or the last (possibly partial) word leaves.
   assign fill_next_zero = ~push & ((fill == '0) | (pop & (fill <= OUT_W_F)));

   always_comb begin
      state_d = state_q;
      case (state_q)
         GB_IDLE: begin
            // A coincident push is counted, so its word joins the drain.
            if (flush & ~fill_next_zero) begin
               state_d = GB_DRAIN;
            end
         end
         GB_DRAIN: begin
            if (fill_next_zero) begin
               state_d = GB_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         state_q <= GB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign flush_pend = (state_q == GB_DRAIN);
   // Final pop of a zero-padded partial word empties the buffer.
   assign drain_last = flush_pend & (fill < OUT_W_F);
`else
   logic unused_flush;

   assign unused_flush = flush;
   assign flush_pend   = 1'b0;
   assign drain_last   = 1'b0;
`endif

   gear_box_bit_buffer #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .BUF_W  (BUF_W),
      .FILL_W (FILL_W)
   ) u_bit_buffer (
      .clk        (clk),
      .sys_reset  (sys_reset),
      .in_data    (in_data),
      .push       (push),
      .pop        (pop),
      .drain_last (drain_last),
      .buf_bits   (buf_bits),
      .fill       (fill)
   );

endmodule

// File: doc/param_gear_box.md
# param_gear_box

Parametrised single-clock width converter. It packs an `IN_W`-bit word stream into an `OUT_W`-bit word stream, or unpacks it, through a bit accumulator of `BUF_W` bits, with valid/ready handshakes on both sides. Bit order is LSB-first: the first bit accepted is the first bit emitted. It is the next-generation replacement for the fixed 13→8 ADC gear box and sits between ADC capture and the byte-wide serializer.

## Interface
- `IN_W`, default 13: input word width, ≥1.
- `OUT_W`, default 8: output word width, ≥1.
- `BUF_W`, default 32: accumulator capacity in bits; must satisfy ≥ `IN_W + OUT_W - 1`.
- `FILL_W`, default `$clog2(BUF_W+1)`: width of the fill counter (derived; do not override).
- `clk`  in  1: the only clock.
- `sys_reset`  in  1: asynchronous, active-high reset.
- `in_data`  in  `IN_W`: input word.
- `in_valid`  in  1: input word present.
- `in_ready`  out  1: accumulator can accept a word.
- `out_data`  out  `OUT_W`: output word.
- `out_valid`  out  1: output word present.
- `out_ready`  in  1: sink accepts the output word.
- `flush`  in  1: single-cycle pulse; emits the residue (see Configuration).
- `fill_level`  out  `FILL_W`: number of valid bits currently held.

## Operation
- State: `buf[BUF_W-1:0]`, `fill`, and `flush_pend` (flush option only).
- Invariant: `buf` bits at and above `fill` are always 0.
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- `in_ready = (fill <= BUF_W-IN_W) & ~flush_pend`. It is a function of registered state only; there is no combinational path from `out_ready`.
- `out_valid = (fill >= OUT_W) | (flush_pend & fill != 0)`. `out_data = buf[OUT_W-1:0]`.
- Pop only: `buf >>= OUT_W`; `fill -= OUT_W`, saturating at 0 for a flushed partial word.
- Push only: `buf |= in_data << fill`; `fill += IN_W`.
- Push and pop in the same cycle: `buf = (buf >> OUT_W) | (in_data << (fill-OUT_W))`; `fill += IN_W - OUT_W`. A push-and-pop always has `fill ≥ OUT_W`, because `flush_pend` blocks pushes.
- Shift and arithmetic are done at `BUF_W+IN_W` bits, then truncated to `BUF_W`. `fill` never exceeds `BUF_W`.
- `in_data` changing while `in_ready` is low is ignored. The bench asserts `out_data` is stable while `out_valid & ~out_ready`.
- Reset, asynchronous and effective mid-transfer: `buf = 0`, `fill = 0`, `flush_pend = 0`. After reset, `out_valid = 0`, `out_data = 0`, `in_ready = 1`, `fill_level = 0`. Partial data is discarded.

## Timing
- Latency is 1 cycle: a push at edge N makes its first bits visible on `out_data` after edge N when `fill` reaches `OUT_W`.
- Sustained throughput is one pop per cycle while input supply keeps `fill ≥ OUT_W`.
- `fill_level` is the registered `fill`.
- Flush option states:
  - IDLE: `flush_pend = 0`.
  - DRAIN: `flush_pend = 1`.
  - A `flush` pulse with `fill != 0` moves IDLE→DRAIN on the next edge.
  - `flush` with `fill == 0` is a no-op.
  - DRAIN→IDLE on the edge where `fill` becomes 0.
  - `flush` while already in DRAIN is ignored.
  - `flush` coincident with a push: the push completes first, and that word is included in the drain.

## Configuration
- Macro: `PARAM_GEAR_BOX_FLUSH_EN`.
- Defined: the `flush` port is live and the DRAIN state exists. The final partial word is emitted with its upper bits zero-padded, and `fill` then returns to 0.
- Undefined: the `flush` port is present but ignored, `flush_pend` is a constant 0, and residue below `OUT_W` bits stays held until more input arrives.

## Structure
- Package `gear_box_pkg` holds:
  - default widths `GB_IN_W = 13`, `GB_OUT_W = 8`, `GB_BUF_W = 32`;
  - the flush state encodings `GB_IDLE` and `GB_DRAIN`;
  - a `clog2` constant function.
- Sub-module `gear_box_bit_buffer` holds the `buf`/`fill` register and the merge/shift datapath. Its inputs are `push`, `pop` and `drain_last`; its outputs are `buf` and `fill`.
- The top level holds the handshake logic and the flush FSM.

## Test plan
- Reset: assert `sys_reset` mid-stream with `fill = 13` → on the same cycle `out_valid = 0`, `in_ready = 1`, `fill_level = 0`; after release, the first byte comes only from new input.
- Packing order (13→8, `out_ready = 1`): push `13'h1ABC`, then `13'h0123` → bytes `8'hBC`, `8'h7A`, `8'h24`; `fill_level` ends at 2.
- Flush (macro defined): continuing from the packing test, pulse `flush` → one extra byte `8'h00` with `out_valid = 1`; then `fill_level = 0` and `in_ready = 1`. With the macro undefined → no byte is emitted and `fill_level` stays 2.
- Backpressure: hold `out_ready = 0` and push `13'h1FFF` twice → `in_ready` drops after the 2nd push (`fill = 26 > 19`); `out_data = 8'hFF` held stable; release `out_ready` → 3 pops, then `in_ready` returns.
- Throughput: 8 back-to-back words 1..8 with `out_ready = 1` → exactly 13 bytes, whose concatenation equals the 104-bit LSB-first packing; `fill_level` ends at 0.
- Unpacking: `IN_W = 8`, `OUT_W = 13`, `BUF_W = 20`; push bytes `8'hBC`, `8'h7A`, `8'h24`, `8'h00` → `13'h1ABC`, then `13'h0123`.
